// File: rtl/video_pkg.sv
// Shared palette constants and index helpers used by the palette lookup
// and its storage.
package video_pkg;

  localparam int PAL_DEPTH = 32;
  localparam int PAL_AW    = 5;
  localparam int ENTRY_W   = 6;

  localparam logic [ENTRY_W-1:0] GREY_MASK = 6'h30;
  localparam logic [ENTRY_W-1:0] FULL_MASK = 6'h3F;
  localparam logic [5:0]         PAL_PAGE  = 6'h3F;

  // Sprite backdrop slots 0x10/14/18/1C alias the background backdrop slots.
  function automatic logic [PAL_AW-1:0] mirror_index(input logic [PAL_AW-1:0] idx);
    if (idx[4] && (idx[1:0] == 2'b00)) mirror_index = {1'b0, idx[3:0]};
    else                               mirror_index = idx;
  endfunction

  function automatic logic [ENTRY_W-1:0] apply_grey(input logic [ENTRY_W-1:0] entry,
                                                    input logic grey);
    apply_grey = entry & (grey ? GREY_MASK : FULL_MASK);
  endfunction

endpackage

// File: rtl/video_palette_ram.sv
// 32x6 palette storage: one write port, two registered read-first read
// ports, synchronous clear that wins over a same-cycle write.
module video_palette_ram
  import video_pkg::*;
(
  input  logic               clk,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [PAL_AW-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_a_en,
  input  logic [PAL_AW-1:0]  rd_a_addr,
  output logic [ENTRY_W-1:0] rd_a_data,
  input  logic               rd_b_en,
  input  logic [PAL_AW-1:0]  rd_b_addr,
  output logic [ENTRY_W-1:0] rd_b_data
);

  logic [ENTRY_W-1:0] mem [PAL_DEPTH];

  // Reads sample mem before the write lands, so a same-edge write is unseen.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < PAL_DEPTH; i++) mem[i] <= '0;
      rd_a_data <= '0;
      rd_b_data <= '0;
    end else begin
      if (wr_en)   mem[wr_addr] <= wr_data;
      if (rd_a_en) rd_a_data    <= mem[rd_a_addr];
      if (rd_b_en) rd_b_data    <= mem[rd_b_addr];
    end
  end

endmodule

// File: rtl/video_palette.sv
// Pixel palette lookup: picks bg/sprite index by opacity and priority,
// resolves it through the palette RAM and applies greyscale/emphasis.
module video_palette
  import video_pkg::*;
(
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_pix_valid,
  input  logic [3:0]  I_bg_color,
  input  logic [3:0]  I_spr_color,
  input  logic        I_spr_behind,
  input  logic [7:0]  I_ppumask,
  input  logic [13:0] I_vram_addr,
  input  logic        I_pal_wr,
  input  logic        I_pal_rd,
  input  logic [7:0]  I_pal_data,
  output logic [7:0]  O_pal_data,
  output logic        O_pix_valid,
  output logic [5:0]  O_color,
  output logic [2:0]  O_emphasis
);

  // Handshake: I_pix_valid marks one pixel per cycle with no backpressure;
  // the matching O_pix_valid appears two rising edges later, and O_color /
  // O_emphasis keep their last value whenever O_pix_valid is low.

  logic              bg_opaque;
  logic              spr_opaque;
  logic [PAL_AW-1:0] pix_idx;
  logic [PAL_AW-1:0] cpu_idx;

  logic              s1_valid;
  logic [PAL_AW-1:0] s1_idx;
  logic [7:0]        s1_mask;
  logic              s2_valid;
  logic [7:0]        s2_mask;
  logic [ENTRY_W-1:0] s2_entry;
  logic              cpu_grey;
  logic [ENTRY_W-1:0] cpu_entry;

  always_comb begin
    bg_opaque  = I_ppumask[3] && (I_bg_color[1:0] != 2'b00);
    spr_opaque = I_ppumask[4] && (I_spr_color[1:0] != 2'b00);
    pix_idx    = '0;
    if ((I_ppumask[4:3] == 2'b00) && (I_vram_addr[13:8] == PAL_PAGE)) begin
      pix_idx = I_vram_addr[4:0];
    end else if (bg_opaque && spr_opaque) begin
      pix_idx = I_spr_behind ? {1'b0, I_bg_color} : {1'b1, I_spr_color};
    end else if (bg_opaque) begin
      pix_idx = {1'b0, I_bg_color};
    end else if (spr_opaque) begin
      pix_idx = {1'b1, I_spr_color};
    end
  end

  assign cpu_idx = mirror_index(I_vram_addr[4:0]);

  // The mask travels with its pixel so a mid-stream PPUMASK write only
  // affects pixels sampled at or after that edge.
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_mask  <= '0;
      s2_valid <= 1'b0;
      s2_mask  <= '0;
      cpu_grey <= 1'b0;
    end else begin
      s1_valid <= I_pix_valid;
      if (I_pix_valid) begin
        s1_idx  <= mirror_index(pix_idx);
        s1_mask <= I_ppumask;
      end
      s2_valid <= s1_valid;
      if (s1_valid) s2_mask <= s1_mask;
      if (I_pal_rd) cpu_grey <= I_ppumask[0];
    end
  end

  video_palette_ram u_ram (
    .clk       (I_clock),
    .clear     (I_reset),
    .wr_en     (I_pal_wr),
    .wr_addr   (cpu_idx),
    .wr_data   (I_pal_data[5:0]),
    .rd_a_en   (s1_valid),
    .rd_a_addr (s1_idx),
    .rd_a_data (s2_entry),
    .rd_b_en   (I_pal_rd),
    .rd_b_addr (cpu_idx),
    .rd_b_data (cpu_entry)
  );

  assign O_pix_valid = s2_valid;
  assign O_color     = apply_grey(s2_entry, s2_mask[0]);
  assign O_emphasis  = s2_mask[7:5];
  assign O_pal_data  = {2'b00, apply_grey(cpu_entry, cpu_grey)};

  logic unused_bits;
  assign unused_bits = ^{I_vram_addr[7:5], I_pal_data[7:6], s2_mask[4:1]};

endmodule

// File: tb/tb_video_palette.sv
// Self-checking bench for video_palette: a reference palette model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_video_palette;

  logic        I_clock;
  logic        I_reset;
  logic        I_pix_valid;
  logic [3:0]  I_bg_color;
  logic [3:0]  I_spr_color;
  logic        I_spr_behind;
  logic [7:0]  I_ppumask;
  logic [13:0] I_vram_addr;
  logic        I_pal_wr;
  logic        I_pal_rd;
  logic [7:0]  I_pal_data;
  logic [7:0]  O_pal_data;
  logic        O_pix_valid;
  logic [5:0]  O_color;
  logic [2:0]  O_emphasis;

  video_palette dut (
    .I_clock      (I_clock),
    .I_reset      (I_reset),
    .I_pix_valid  (I_pix_valid),
    .I_bg_color   (I_bg_color),
    .I_spr_color  (I_spr_color),
    .I_spr_behind (I_spr_behind),
    .I_ppumask    (I_ppumask),
    .I_vram_addr  (I_vram_addr),
    .I_pal_wr     (I_pal_wr),
    .I_pal_rd     (I_pal_rd),
    .I_pal_data   (I_pal_data),
    .O_pal_data   (O_pal_data),
    .O_pix_valid  (O_pix_valid),
    .O_color      (O_color),
    .O_emphasis   (O_emphasis)
  );

  // ---------------- clock / reset ----------------
  initial I_clock = 1'b0;
  always #5 I_clock = ~I_clock;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [5:0] ref_pal [32];
  logic       m_pend_valid;
  logic [4:0] m_pend_idx;
  logic [7:0] m_pend_mask;
  logic       m_valid;
  logic [5:0] m_color;
  logic [2:0] m_emph;
  logic [7:0] m_pal;

  function automatic logic [4:0] fold(input logic [4:0] idx);
    if (idx == 5'h10 || idx == 5'h14 || idx == 5'h18 || idx == 5'h1C) return idx - 5'd16;
    return idx;
  endfunction

  function automatic logic [5:0] grey(input logic [5:0] e, input logic g);
    return g ? {e[5:4], 4'b0000} : e;
  endfunction

  function automatic logic [4:0] pick(input logic [3:0] bg, input logic [3:0] spr,
                                      input logic behind, input logic [7:0] mask,
                                      input logic [13:0] vram);
    logic bo, so;
    if (mask[4:3] == 2'b00 && vram[13:8] == 6'h3F) return fold(vram[4:0]);
    bo = mask[3] && (bg[1:0] != 0);
    so = mask[4] && (spr[1:0] != 0);
    if (so && !(bo && behind)) return fold({1'b1, spr});
    if (bo) return fold({1'b0, bg});
    return 5'h00;
  endfunction

  // A pixel sampled at edge N reads the palette at edge N+1, before that
  // edge's write; CPU reads likewise see the pre-write contents.
  always @(posedge I_clock) begin
    if (I_reset) begin
      for (int i = 0; i < 32; i++) ref_pal[i] = 6'h00;
      m_pend_valid = 1'b0; m_pend_idx = '0; m_pend_mask = '0;
      m_valid = 1'b0; m_color = '0; m_emph = '0; m_pal = '0;
    end else begin
      m_valid = m_pend_valid;
      if (m_pend_valid) begin
        m_color = grey(ref_pal[m_pend_idx], m_pend_mask[0]);
        m_emph  = m_pend_mask[7:5];
      end
      if (I_pal_rd) m_pal = {2'b00, grey(ref_pal[fold(I_vram_addr[4:0])], I_ppumask[0])};
      if (I_pal_wr) ref_pal[fold(I_vram_addr[4:0])] = I_pal_data[5:0];
      m_pend_valid = I_pix_valid;
      if (I_pix_valid) begin
        m_pend_idx  = pick(I_bg_color, I_spr_color, I_spr_behind, I_ppumask, I_vram_addr);
        m_pend_mask = I_ppumask;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge I_clock) begin
    if (check_en) begin
      check("cyc_pix_valid", {7'b0, O_pix_valid}, {7'b0, m_valid});
      check("cyc_color",     {2'b0, O_color},     {2'b0, m_color});
      check("cyc_emphasis",  {5'b0, O_emphasis},  {5'b0, m_emph});
      check("cyc_pal_data",  O_pal_data,          m_pal);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pal_write(input logic [13:0] addr, input logic [7:0] data);
    I_vram_addr = addr; I_pal_data = data; I_pal_wr = 1'b1;
    @(negedge I_clock);
    I_pal_wr = 1'b0;
  endtask

  task automatic pal_read(input string name, input logic [13:0] addr, input logic [7:0] mask,
                          input logic [7:0] exp);
    I_vram_addr = addr; I_ppumask = mask; I_pal_rd = 1'b1;
    @(negedge I_clock);
    I_pal_rd = 1'b0;
    check(name, O_pal_data, exp);
  endtask

  task automatic pixel(input logic [3:0] bg, input logic [3:0] spr, input logic behind,
                       input logic [7:0] mask, input logic [13:0] vram);
    I_bg_color = bg; I_spr_color = spr; I_spr_behind = behind;
    I_ppumask = mask; I_vram_addr = vram; I_pix_valid = 1'b1;
    @(negedge I_clock);
    I_pix_valid = 1'b0;
  endtask

  task automatic pixel_check(input string name, input logic [3:0] bg, input logic [3:0] spr,
                             input logic behind, input logic [7:0] mask, input logic [13:0] vram,
                             input logic [5:0] exp_color, input logic [2:0] exp_emph);
    pixel(bg, spr, behind, mask, vram);
    @(negedge I_clock);
    check({name, "_valid"}, {7'b0, O_pix_valid}, 8'h01);
    check({name, "_color"}, {2'b0, O_color}, {2'b0, exp_color});
    check({name, "_emph"},  {5'b0, O_emphasis}, {5'b0, exp_emph});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    I_reset = 1'b1; I_pix_valid = 1'b0; I_bg_color = '0; I_spr_color = '0;
    I_spr_behind = 1'b0; I_ppumask = '0; I_vram_addr = '0;
    I_pal_wr = 1'b0; I_pal_rd = 1'b0; I_pal_data = '0;
    @(negedge I_clock);
    check_en = 1'b1;
    @(negedge I_clock);
    check("rst_pix_valid", {7'b0, O_pix_valid}, 8'h00);
    check("rst_color",     {2'b0, O_color},     8'h00);
    check("rst_emph",      {5'b0, O_emphasis},  8'h00);
    check("rst_pal_data",  O_pal_data,          8'h00);
    I_reset = 1'b0;
    @(negedge I_clock);

    // Background pixel through written entry 1
    pal_write(14'h3F01, 8'h2A);
    pixel_check("bg1", 4'h1, 4'h0, 1'b0, 8'h08, 14'h0000, 6'h2A, 3'b000);

    // Sprite backdrop write aliases the universal backdrop
    pal_write(14'h3F10, 8'h15);
    pal_read("mirror_rd", 14'h3F00, 8'h00, 8'h15);
    pixel_check("backdrop", 4'h0, 4'h0, 1'b0, 8'h18, 14'h0000, 6'h15, 3'b000);
    pal_write(14'h3F04, 8'h3A);
    pal_read("mirror_rd14", 14'h3F14, 8'h00, 8'h3A);

    // Priority between two opaque layers
    pal_write(14'h3F16, 8'h21);
    pal_write(14'h3F05, 8'h0B);
    pixel_check("spr_front", 4'h5, 4'h6, 1'b0, 8'h18, 14'h0000, 6'h21, 3'b000);
    pixel_check("spr_behind", 4'h5, 4'h6, 1'b1, 8'h18, 14'h0000, 6'h0B, 3'b000);

    // Greyscale and emphasis
    pixel_check("grey", 4'h0, 4'h0, 1'b0, 8'h01, 14'h3F01, 6'h20, 3'b000);
    pixel_check("emph", 4'h1, 4'h0, 1'b0, 8'hE8, 14'h0000, 6'h2A, 3'b111);
    pal_read("grey_rd", 14'h3F01, 8'h01, 8'h20);

    // Rendering off: backdrop override only inside the palette page
    pal_write(14'h3F07, 8'h11);
    pixel_check("ovr_3f07", 4'h0, 4'h0, 1'b0, 8'h00, 14'h3F07, 6'h11, 3'b000);
    pixel_check("ovr_2000", 4'h0, 4'h0, 1'b0, 8'h00, 14'h2000, 6'h15, 3'b000);

    // Pixel lookup colliding with a write to its entry sees the old value
    pixel(4'h1, 4'h0, 1'b0, 8'h08, 14'h0000);
    I_vram_addr = 14'h3F01; I_pal_data = 8'h33; I_pal_wr = 1'b1;
    I_pix_valid = 1'b1;
    @(negedge I_clock);
    I_pal_wr = 1'b0; I_pix_valid = 1'b0;
    check("rdfirst_old", {2'b0, O_color}, 8'h2A);
    @(negedge I_clock);
    check("rdfirst_new", {2'b0, O_color}, 8'h33);
    @(negedge I_clock);
    check("hold_valid", {7'b0, O_pix_valid}, 8'h00);
    check("hold_color", {2'b0, O_color}, 8'h33);

    // Simultaneous CPU read and write of one entry
    I_vram_addr = 14'h3F05; I_pal_data = 8'h2C; I_ppumask = 8'h00;
    I_pal_wr = 1'b1; I_pal_rd = 1'b1;
    @(negedge I_clock);
    I_pal_wr = 1'b0; I_pal_rd = 1'b0;
    check("rdwr_old", O_pal_data, 8'h0B);
    pal_read("rdwr_new", 14'h3F05, 8'h00, 8'h2C);

    // Mask change mid-stream: each pixel keeps the mask it entered with
    pixel(4'h1, 4'h0, 1'b0, 8'h08, 14'h0000);
    I_ppumask = 8'h09; I_pix_valid = 1'b1;
    @(negedge I_clock);
    I_pix_valid = 1'b0;
    check("mask_old", {2'b0, O_color}, 8'h33);
    @(negedge I_clock);
    check("mask_new", {2'b0, O_color}, 8'h30);

    // Reset with pixels in flight and a colliding write
    I_bg_color = 4'h1; I_ppumask = 8'hE8; I_pix_valid = 1'b1;
    @(negedge I_clock);
    @(negedge I_clock);
    I_reset = 1'b1; I_pal_wr = 1'b1; I_vram_addr = 14'h3F01; I_pal_data = 8'h3F;
    @(negedge I_clock);
    I_reset = 1'b0; I_pal_wr = 1'b0; I_pix_valid = 1'b0;
    check("rst2_valid", {7'b0, O_pix_valid}, 8'h00);
    check("rst2_color", {2'b0, O_color}, 8'h00);
    check("rst2_emph",  {5'b0, O_emphasis}, 8'h00);
    check("rst2_pal",   O_pal_data, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(negedge I_clock);
      check("rst2_novalid", {7'b0, O_pix_valid}, 8'h00);
    end
    pal_read("rst2_ram01", 14'h3F01, 8'h00, 8'h00);
    pal_read("rst2_ram16", 14'h3F16, 8'h00, 8'h00);

    // Mixed random traffic checked against the model every cycle
    for (int n = 0; n < 300; n++) begin
      I_pix_valid  = ($urandom_range(0, 3) != 0);
      I_bg_color   = 4'($urandom_range(0, 15));
      I_spr_color  = 4'($urandom_range(0, 15));
      I_spr_behind = 1'($urandom_range(0, 1));
      I_ppumask    = 8'($urandom_range(0, 255));
      I_vram_addr  = {($urandom_range(0, 1) != 0) ? 6'h3F : 6'($urandom_range(0, 63)),
                      8'($urandom_range(0, 255))};
      I_pal_data   = 8'($urandom_range(0, 255));
      I_pal_wr     = ($urandom_range(0, 3) == 0);
      I_pal_rd     = ($urandom_range(0, 3) == 0);
      @(negedge I_clock);
    end
    I_pix_valid = 1'b0; I_pal_wr = 1'b0; I_pal_rd = 1'b0;
    repeat (3) @(negedge I_clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_palette.md
VIDEO_PALETTE -- requirements
Module: video_palette

Interface
REQ-001 SHALL: I_clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: I_reset  input  1  synchronous, active-high reset, sampled on the rising edge of I_clock.
REQ-003 SHALL: I_pix_valid  input  1  qualifies the pixel inputs for this cycle.
REQ-004 SHALL: I_bg_color  input  4  background pixel {attr[1:0], pattern[1:0]} from video_composite O_color.
REQ-005 SHALL: I_spr_color  input  4  sprite pixel {palette[1:0], pattern[1:0]}.
REQ-006 SHALL: I_spr_behind  input  1  sprite priority; 1 = behind an opaque background.
REQ-007 SHALL: I_ppumask  input  8  PPUMASK register: bit0 greyscale, bit3 bg enable, bit4 spr enable, bits7:5 emphasis.
REQ-008 SHALL: I_vram_addr  input  14  current VRAM address v.
REQ-009 SHALL: I_pal_wr, I_pal_rd  input  1 each  CPU palette write/read strobes; one cycle each.
REQ-010 SHALL: I_pal_data  input  8  CPU write data; bits 5:0 are stored.
REQ-011 SHALL: O_pal_data  output  8  CPU read data {2'b00, entry}.
REQ-012 SHALL: O_pix_valid  output  1  qualifies O_color and O_emphasis.
REQ-013 SHALL: O_color  output  6  master-palette colour index.
REQ-014 SHALL: O_emphasis  output  3  emphasis bits forwarded to the encoder.

Function
REQ-015 SHALL: layer opacity -- bg opaque iff I_ppumask[3] and I_bg_color[1:0]!=0; spr opaque iff I_ppumask[4] and I_spr_color[1:0]!=0.
REQ-016 SHALL: index select -- neither opaque -> 5'h00; bg only -> {0,bg}; spr only -> {1,spr}; both opaque -> I_spr_behind ? {0,bg} : {1,spr}.
REQ-017 SHALL: when I_ppumask[4:3]==0 and I_vram_addr[13:8]==6'h3F, use index I_vram_addr[4:0] (backdrop override).
REQ-018 SHALL: mirroring -- any index with bit4=1 and bits[1:0]=0 maps to bit4 cleared (0x10/14/18/1C -> 0x00/04/08/0C), for all reads and writes.
REQ-019 SHALL: two-stage pipeline -- stage 1 registers the mirrored index, valid and ppumask; stage 2 registers the RAM entry; O_pix_valid rises exactly 2 cycles after I_pix_valid.
REQ-020 SHALL: greyscale -- when stage-2 ppumask bit0=1, O_color = entry & 6'h30.
REQ-021 SHALL: O_emphasis = stage-2 ppumask[7:5], aligned with O_color.
REQ-022 SHALL: when O_pix_valid=0, O_color and O_emphasis hold their last values.
REQ-023 SHALL: CPU write -- I_pal_wr writes RAM[mirror(I_vram_addr[4:0])] <= I_pal_data[5:0] at the same edge.
REQ-024 SHALL: CPU read -- I_pal_rd yields O_pal_data = {2'b00, greyscale-applied entry} 1 cycle later, held until the next read.
REQ-025 SHALL: a pixel read and a write to the same entry in the same cycle return the old value (read-first); the following pixel sees the new value.
REQ-026 SHALL: simultaneous I_pal_wr and I_pal_rd -- the write occurs and the read returns the old value.
REQ-027 SHALL: an I_ppumask change affects only pixels entering stage 1 at or after that edge.

Reset
REQ-028 SHALL: I_reset clears all 32 palette entries, both pipeline stages, O_pix_valid, O_color, O_emphasis and O_pal_data to 0 in one cycle.
REQ-029 SHALL: I_reset mid-pipeline discards in-flight pixels, with no O_pix_valid pulse after reset; the reset dominates a same-cycle write.

Structure
REQ-030 SHALL: a shared video_pkg holds the palette depth (32), entry width (6), the greyscale mask 6'h30, the 3F page constant, and the mirror-index function.
REQ-031 SHALL: video_palette_ram (32x6, one write port, two read-first read ports, synchronous clear) is the single sub-module.

Verification
REQ-032 SHALL: write 0x3F01=0x2A, bg_color=4'h1, mask=0x08 -> O_color=0x2A two cycles later with O_pix_valid=1.
REQ-033 SHALL: write 0x3F10=0x15, then read 0x3F00 -> O_pal_data=0x15; spr_color=4'h0 with bg transparent -> O_color=0x15.
REQ-034 SHALL: bg=4'h5 and spr=4'h6 both opaque, mask=0x18 -> index 0x16 with I_spr_behind=0, index 0x05 with I_spr_behind=1.
REQ-035 SHALL: mask=0x01, entry 0x2A -> O_color=0x20; mask=0xE8 -> O_emphasis=3'b111.
REQ-036 SHALL: mask=0x00, vram_addr=0x3F07 with entry 0x07=0x11 -> O_color=0x11; vram_addr=0x2000 -> entry 0x00.
REQ-037 SHALL: assert I_reset while valid pixels are in flight -> all outputs 0, no O_pix_valid for 2 cycles, RAM reads 0.
